// File: rtl/l15_simple_master_pkg.sv
// Shared L1.5 request/return encodings and state encoding for l15_simple_master.
package l15_simple_master_pkg;

  localparam logic [4:0] LOAD_RQ   = 5'b00000;
  localparam logic [4:0] STORE_RQ  = 5'b00001;

  localparam logic [3:0] LOAD_RET  = 4'b0000;
  localparam logic [3:0] ST_ACK    = 4'b0100;
  localparam logic [3:0] EVICT_REQ = 4'b0011;
  localparam logic [3:0] INT_RET   = 4'b0111;

  localparam int THREADID_W = 1;
  localparam int AMO_OP_W   = 4;
  localparam int L1RPLWAY_W = 2;
  localparam int CSM_W      = 33;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_REQ  = 2'b01,
    ST_WAIT = 2'b10,
    ST_DONE = 2'b11
  } state_e;

  // A return completes the outstanding request only if its type matches the request kind.
  function automatic logic ret_matches(input logic is_store, input logic [3:0] rtype);
    logic m;
    if (is_store) begin
      m = (rtype == ST_ACK);
    end else begin
      m = (rtype == LOAD_RET);
    end
    return m;
  endfunction

endpackage

// File: rtl/l15_store_replicate.sv
// Replicates right-aligned store data across the 64-bit L1.5 data bus by access size.
module l15_store_replicate
  import l15_simple_master_pkg::*;
(
  input  logic [2:0]  size,
  input  logic [63:0] wdata,
  output logic [63:0] data
);

  // Size-based lane replication
  always_comb begin
    data = wdata;
    case (size)
      3'b000:  data = {8{wdata[7:0]}};
      3'b001:  data = {4{wdata[15:0]}};
      3'b010:  data = {2{wdata[31:0]}};
      3'b011:  data = wdata;
      default: data = wdata;
    endcase
  end

endmodule

// File: rtl/l15_simple_master.sv
// Single-outstanding host load/store initiator on the L1.5 transducer interface.
// Optional response timeout enabled by defining L15_SIMPLE_MASTER_TIMEOUT_EN.
module l15_simple_master
  import l15_simple_master_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 65535
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  host_req_val,
  output logic                  host_req_rdy,
  input  logic                  host_req_we,
  input  logic                  host_req_nc,
  input  logic [2:0]            host_req_size,
  input  logic [39:0]           host_req_addr,
  input  logic [63:0]           host_req_wdata,
  output logic                  host_resp_val,
  input  logic                  host_resp_rdy,
  output logic [63:0]           host_resp_rdata,
  output logic                  host_resp_err,
  output logic                  transducer_l15_val,
  output logic [4:0]            transducer_l15_rqtype,
  output logic                  transducer_l15_nc,
  output logic [2:0]            transducer_l15_size,
  output logic [39:0]           transducer_l15_address,
  output logic [63:0]           transducer_l15_data,
  output logic [THREADID_W-1:0] transducer_l15_threadid,
  output logic [AMO_OP_W-1:0]   transducer_l15_amo_op,
  output logic                  transducer_l15_prefetch,
  output logic                  transducer_l15_blockstore,
  output logic                  transducer_l15_blockinitstore,
  output logic                  transducer_l15_invalidate_cacheline,
  output logic [L1RPLWAY_W-1:0] transducer_l15_l1rplway,
  output logic [63:0]           transducer_l15_data_next_entry,
  output logic [CSM_W-1:0]      transducer_l15_csm_data,
  input  logic                  l15_transducer_ack,
  input  logic                  l15_transducer_val,
  input  logic [3:0]            l15_transducer_returntype,
  input  logic [63:0]           l15_transducer_data_0,
  input  logic [63:0]           l15_transducer_data_1,
  output logic                  transducer_l15_req_ack
);

  state_e      state_r, state_next_s;
  logic        accept_s, issued_s, match_s, timeout_s;
  logic        val_r, nc_r, is_store_r, err_r;
  logic [4:0]  rqtype_r;
  logic [2:0]  size_r;
  logic [39:0] addr_r;
  logic [63:0] data_r, rdata_r, repl_data_s, ret_data_s;

  l15_store_replicate u_repl (
    .size  (host_req_size),
    .wdata (host_req_wdata),
    .data  (repl_data_s)
  );

  // Next-state decode and handshake qualifiers
  always_comb begin
    state_next_s = state_r;
    accept_s     = 1'b0;
    issued_s     = 1'b0;
    match_s      = 1'b0;
    if (l15_transducer_val && ret_matches(is_store_r, l15_transducer_returntype)) begin
      ret_data_s = is_store_r ? 64'd0 :
                   (addr_r[3] ? l15_transducer_data_1 : l15_transducer_data_0);
    end else begin
      ret_data_s = 64'd0;
    end
    case (state_r)
      ST_IDLE: begin
        if (host_req_val) begin
          accept_s     = 1'b1;
          state_next_s = ST_REQ;
        end else begin
          state_next_s = ST_IDLE;
        end
      end
      ST_REQ: begin
        if (l15_transducer_ack) begin
          issued_s     = 1'b1;
          state_next_s = ST_WAIT;
        end else begin
          state_next_s = ST_REQ;
        end
      end
      ST_WAIT: begin
        if (l15_transducer_val && ret_matches(is_store_r, l15_transducer_returntype)) begin
          match_s      = 1'b1;
          state_next_s = ST_DONE;
        end else if (timeout_s) begin
          state_next_s = ST_DONE;
        end else begin
          state_next_s = ST_WAIT;
        end
      end
      ST_DONE: begin
        if (host_resp_rdy) begin
          state_next_s = ST_IDLE;
        end else begin
          state_next_s = ST_DONE;
        end
      end
      default: state_next_s = ST_IDLE;
    endcase
  end

  // State, request fields and response registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r    <= ST_IDLE;
      val_r      <= 1'b0;
      rqtype_r   <= 5'd0;
      nc_r       <= 1'b0;
      size_r     <= 3'd0;
      addr_r     <= 40'd0;
      data_r     <= 64'd0;
      is_store_r <= 1'b0;
      rdata_r    <= 64'd0;
      err_r      <= 1'b0;
    end else begin
      state_r <= state_next_s;
      if (accept_s) begin
        val_r      <= 1'b1;
        rqtype_r   <= host_req_we ? STORE_RQ : LOAD_RQ;
        nc_r       <= host_req_nc;
        size_r     <= host_req_size;
        addr_r     <= host_req_addr;
        data_r     <= host_req_we ? repl_data_s : 64'd0;
        is_store_r <= host_req_we;
        err_r      <= 1'b0;
      end else if (issued_s) begin
        val_r <= 1'b0;
      end
      if (match_s) begin
        rdata_r <= ret_data_s;
        err_r   <= 1'b0;
      end else if (timeout_s) begin
        rdata_r <= 64'd0;
        err_r   <= 1'b1;
      end
    end
  end

`ifdef L15_SIMPLE_MASTER_TIMEOUT_EN
  logic [15:0] tmo_cnt_r;

  // Response-wait counter, restarted as the request is accepted by the L1.5
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tmo_cnt_r <= 16'd0;
    end else if (issued_s) begin
      tmo_cnt_r <= 16'd0;
    end else if (state_r == ST_WAIT) begin
      tmo_cnt_r <= tmo_cnt_r + 16'd1;
    end
  end

  assign timeout_s = (state_r == ST_WAIT) && (tmo_cnt_r == 16'(TIMEOUT_CYCLES - 32'd1));
`else
  // Without the counter the limit has no effect; WAIT holds until a matching return.
  assign timeout_s = (TIMEOUT_CYCLES == 32'd0) && 1'b0;
`endif

  assign host_req_rdy           = (state_r == ST_IDLE);
  assign host_resp_val          = (state_r == ST_DONE);
  assign host_resp_rdata        = rdata_r;
  assign host_resp_err          = err_r;
  assign transducer_l15_val     = val_r;
  assign transducer_l15_rqtype  = rqtype_r;
  assign transducer_l15_nc      = nc_r;
  assign transducer_l15_size    = size_r;
  assign transducer_l15_address = addr_r;
  assign transducer_l15_data    = data_r;
  assign transducer_l15_req_ack = l15_transducer_val;

  assign transducer_l15_threadid             = {THREADID_W{1'b0}};
  assign transducer_l15_amo_op               = {AMO_OP_W{1'b0}};
  assign transducer_l15_prefetch             = 1'b0;
  assign transducer_l15_blockstore           = 1'b0;
  assign transducer_l15_blockinitstore       = 1'b0;
  assign transducer_l15_invalidate_cacheline = 1'b0;
  assign transducer_l15_l1rplway             = {L1RPLWAY_W{1'b0}};
  assign transducer_l15_data_next_entry      = 64'd0;
  assign transducer_l15_csm_data             = {CSM_W{1'b0}};

endmodule

// File: doc/l15_simple_master.md
# l15_simple_master

Single-outstanding request initiator that drives the transducer side of the L1.5 request/response interface. It takes a simple host load/store request, issues it to the L1.5, and holds it until the L1.5 accepts it. It then waits for the matching return, acknowledges that return, and hands the data back to the host. It sits between a lightweight accelerator or test master and `l15_wrap`, in the position a core transducer normally occupies.

## Interface
Parameters:
- `TIMEOUT_CYCLES`, 65535: response-wait limit. Only used when the timeout feature is compiled in.

Ports (one clock; reset is asynchronous and active-low):
- `clk`  in  1  clock
- `rst_n`  in  1  async active-low reset
- `host_req_val`  in  1  host request valid
- `host_req_rdy`  out  1  block can accept a request
- `host_req_we`  in  1  1 = store, 0 = load
- `host_req_nc`  in  1  noncacheable
- `host_req_size`  in  3  000 = 1B, 001 = 2B, 010 = 4B, 011 = 8B
- `host_req_addr`  in  40  byte address
- `host_req_wdata`  in  64  store data, right-aligned
- `host_resp_val`  out  1  response valid
- `host_resp_rdy`  in  1  host takes response
- `host_resp_rdata`  out  64  load data
- `host_resp_err`  out  1  timeout error
- `transducer_l15_val`, `_rqtype[4:0]`, `_nc`, `_size[2:0]`, `_address[39:0]`, `_data[63:0]`  out  request fields
- Remaining `transducer_l15_*` request outputs  out  tied to constant 0: `threadid`, `amo_op`, `prefetch`, `blockstore`, `blockinitstore`, `invalidate_cacheline`, `l1rplway`, `data_next_entry`, `csm_data`
- `l15_transducer_ack`  in  1  request accepted
- `l15_transducer_val`  in  1  return valid
- `l15_transducer_returntype`  in  4  return type
- `l15_transducer_data_0` / `_1`  in  64  return data
- `transducer_l15_req_ack`  out  1  return consumed

## Operation
- States: IDLE, REQ, WAIT, DONE.
- `host_req_rdy` = (state == IDLE).
- Request fields are registered on host accept:
  - rqtype is LOAD_RQ 5'b00000 or STORE_RQ 5'b00001.
  - Store data is replicated across 64 bits according to size: 1B gives 8 copies of byte 0, 2B gives 4 copies, 4B gives 2 copies, 8B passes through.
- IDLE → REQ on `host_req_val`.
- REQ → WAIT on `l15_transducer_ack`.
- In WAIT, a return is matching when its returntype is LOAD_RET 4'b0000 for a load or ST_ACK 4'b0100 for a store.
  - Matching return: latch data and go to DONE. Load data is `data_1` if `addr[3]`, else `data_0`. Store data is 0.
- DONE → IDLE on `host_resp_rdy`. `host_resp_val` = (state == DONE).
- Non-matching returns in any state, including EVICT_REQ 4'b0011 and INT_RET 4'b0111, are acknowledged and dropped. State is unchanged.
- All returns outside WAIT are likewise acknowledged and dropped.

## Timing
- Reset values:
  - state IDLE.
  - All registered outputs 0: `transducer_l15_val`, rqtype, size, address, data, `host_resp_rdata`, `host_resp_err`.
  - `host_req_rdy` is 1 once reset deasserts.
- Request issue:
  - `transducer_l15_val` rises the cycle after host accept.
  - Fields are held stable while val is high.
  - val falls the cycle after `l15_transducer_ack` is sampled.
  - Minimum val pulse is 1 cycle; ack in the first val cycle is legal.
- `transducer_l15_req_ack` = `l15_transducer_val`, combinational, same cycle, for every return type and every state.
- Latency:
  - `host_resp_val` rises the cycle after the matching return.
  - Best-case host accept to `host_resp_val` is 3 cycles.
- No second request is accepted before DONE → IDLE.
- `host_req_rdy` rises the cycle after the response handshake.
- Ack and return in the same cycle while in REQ: the return is not matching (state is not WAIT), so it is acked and dropped.
- Reset asserted mid-operation forces IDLE immediately and drops val. Any pending L1.5 return arrives later in IDLE and is acked and dropped.

## Configuration
- Macro `L15_SIMPLE_MASTER_TIMEOUT_EN`.
- Defined:
  - A 16-bit counter clears on entry to WAIT and increments each WAIT cycle.
  - When the count reaches `TIMEOUT_CYCLES`, go to DONE with `host_resp_err` = 1 and rdata = 0.
  - A late return arrives in IDLE and is acked and dropped.
- Undefined: no counter. WAIT persists indefinitely and `host_resp_err` is constant 0.

## Structure
- Shared package/header holds the constants LOAD_RQ, STORE_RQ, LOAD_RET, ST_ACK, EVICT_REQ and INT_RET, plus the 2-bit state encoding. These come from the existing L1.5 define set; they are not redefined locally.
- One natural sub-module: `l15_store_replicate`, a combinational size-based data replicator.
- FSM and registers stay in the top module.

## Test plan
- 8B load to addr 0x00_8000_0008; L1.5 acks after 2 cycles; LOAD_RET with data_1 = 0xDEADBEEF_CAFEF00D → rdata = 0xDEADBEEF_CAFEF00D, err = 0, req_ack pulses once.
- 1B store of wdata 0xAB → transducer data = 0xABABABAB_ABABABAB, rqtype = 00001, size = 000; ST_ACK → resp_val with rdata = 0.
- EVICT_REQ return injected during WAIT, then LOAD_RET → both acked same cycle; only the LOAD_RET completes the request.
- Ack delayed 10 cycles → val and fields held stable all 10 cycles; val falls exactly one cycle after ack.
- `host_resp_rdy` held low 5 cycles in DONE → resp_val and rdata stable; `host_req_rdy` stays 0 until the handshake.
- With TIMEOUT_EN and `TIMEOUT_CYCLES` = 20, no return → err = 1 after 20 WAIT cycles; a later LOAD_RET in IDLE is acked and ignored.
